prbs_par_gen_chk: RTL and testbench

Parametrised parallel PRBS generator and self-synchronising checker, the multi-polynomial, multi-width successor to the fixed 8/9-bit PRBS pair in `lib_prbs_gen_chk`. It produces `DATA_W` bits of PRBS per enabled cycle and checks a received parallel stream against the same polynomial. It provides lock detection, single-word error injection and a saturating bit-error counter. It sits at link-test points such as SerDes loopback and board BIST, driven by a local CPU or test harness.

---
 rtl/prbs_pkg.sv | 94 +++++++++
 rtl/prbs_par_chk.sv | 129 ++++++++++++
 rtl/prbs_par_gen_chk.sv | 89 ++++++++
 tb/tb_prbs_par_gen_chk.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial select, checker states and a parallel LFSR stepper.
package prbs_pkg;

  localparam int unsigned MAX_ORDER = 31;
  localparam int unsigned MAX_W     = 64;

  localparam int unsigned ORDER_PRBS7  = 7;
  localparam int unsigned TAP_PRBS7    = 6;
  localparam int unsigned ORDER_PRBS9  = 9;
  localparam int unsigned TAP_PRBS9    = 5;
  localparam int unsigned ORDER_PRBS15 = 15;
  localparam int unsigned TAP_PRBS15   = 14;
  localparam int unsigned ORDER_PRBS23 = 23;
  localparam int unsigned TAP_PRBS23   = 18;
  localparam int unsigned ORDER_PRBS31 = 31;
  localparam int unsigned TAP_PRBS31   = 28;

  typedef enum logic [2:0] {
    ModePrbs7  = 3'd0,
    ModePrbs9  = 3'd1,
    ModePrbs15 = 3'd2,
    ModePrbs23 = 3'd3,
    ModePrbs31 = 3'd4
  } prbs_mode_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  typedef struct packed {
    logic [MAX_W-1:0]     bits;
    logic [MAX_ORDER-1:0] state;
  } prbs_step_t;

  function automatic prbs_mode_t prbs_decode(input logic [2:0] mode);
    prbs_mode_t m;
    case (mode)
      3'd1:    m = ModePrbs9;
      3'd2:    m = ModePrbs15;
      3'd3:    m = ModePrbs23;
      3'd4:    m = ModePrbs31;
      default: m = ModePrbs7;
    endcase
    return m;
  endfunction

  // History bit holding the sample order(mode) steps back; bit 0 is the newest sample.
  function automatic logic [4:0] prbs_hi(input prbs_mode_t mode);
    logic [4:0] idx;
    case (mode)
      ModePrbs9:  idx = 5'(ORDER_PRBS9 - 1);
      ModePrbs15: idx = 5'(ORDER_PRBS15 - 1);
      ModePrbs23: idx = 5'(ORDER_PRBS23 - 1);
      ModePrbs31: idx = 5'(ORDER_PRBS31 - 1);
      default:    idx = 5'(ORDER_PRBS7 - 1);
    endcase
    return idx;
  endfunction

  function automatic logic [4:0] prbs_lo(input prbs_mode_t mode);
    logic [4:0] idx;
    case (mode)
      ModePrbs9:  idx = 5'(TAP_PRBS9 - 1);
      ModePrbs15: idx = 5'(TAP_PRBS15 - 1);
      ModePrbs23: idx = 5'(TAP_PRBS23 - 1);
      ModePrbs31: idx = 5'(TAP_PRBS31 - 1);
      default:    idx = 5'(TAP_PRBS7 - 1);
    endcase
    return idx;
  endfunction

  // Advances the LFSR n steps; the first generated bit ends up at bits[n-1].
  function automatic prbs_step_t prbs_next(input logic [MAX_ORDER-1:0] state,
                                           input prbs_mode_t mode, input int unsigned n);
    prbs_step_t r;
    logic       nb;
    logic [4:0] hi;
    logic [4:0] lo;
    hi      = prbs_hi(mode);
    lo      = prbs_lo(mode);
    r.bits  = '0;
    r.state = state;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < n) begin
        nb      = r.state[hi] ^ r.state[lo];
        r.state = {r.state[MAX_ORDER-2:0], nb};
        r.bits  = {r.bits[MAX_W-2:0], nb};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs_par_chk.sv
// Self-synchronising parallel PRBS checker: mismatch vector, lock FSM and saturating bit-error count.
module prbs_par_chk
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  prbs_mode_t        mode_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              cnt_clr_i,
  output logic              locked_o,
  output logic              err_detect_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned POP_W = $clog2(DATA_W + 1);
  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned ERR_W = $clog2(UNLOCK_ERR + 1);
  localparam int unsigned SUM_W = CNT_W + POP_W;

  logic [MAX_ORDER-1:0] hist_q, hist_d, hist_shift;
  logic [DATA_W-1:0]    mism;
  logic [POP_W-1:0]     pop;
  logic [SUM_W-1:0]     sum;
  logic [CNT_W-1:0]     cnt_sat;
  logic [4:0]           hi, lo;
  chk_state_t           state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [ERR_W-1:0]     erun_q, erun_d;
  logic                 err_det_q, err_det_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  assign hi = prbs_hi(mode_i);
  assign lo = prbs_lo(mode_i);

  // Each received bit is predicted from earlier received bits, so a flip shows up three times.
  always_comb begin
    hist_shift = hist_q;
    mism       = '0;
    pop        = '0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      mism[i]    = rx_data_i[i] ^ hist_shift[hi] ^ hist_shift[lo];
      hist_shift = {hist_shift[MAX_ORDER-2:0], rx_data_i[i]};
      pop        = pop + POP_W'(mism[i]);
    end
  end

  assign sum     = SUM_W'(cnt_q) + SUM_W'(pop);
  assign cnt_sat = (sum[SUM_W-1:CNT_W] != '0) ? '1 : sum[CNT_W-1:0];

  always_comb begin
    hist_d    = hist_q;
    state_d   = state_q;
    run_d     = run_q;
    erun_d    = erun_q;
    err_det_d = 1'b0;
    cnt_d     = cnt_q;
    if (clear_i) begin
      hist_d  = '0;
      state_d = SEARCH;
      run_d   = '0;
      erun_d  = '0;
    end else if (rx_valid_i) begin
      hist_d = hist_shift;
      unique case (state_q)
        SEARCH: begin
          // An all-zero word is self-consistent, so it must not count towards lock.
          if (mism == '0 && rx_data_i != '0) begin
            if (run_q == RUN_W'(LOCK_CNT - 1)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          cnt_d = cnt_sat;
          if (mism != '0) begin
            err_det_d = 1'b1;
            if (erun_q == ERR_W'(UNLOCK_ERR - 1)) begin
              state_d = SEARCH;
              erun_d  = '0;
            end else begin
              erun_d = erun_q + 1'b1;
            end
          end else begin
            erun_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    if (cnt_clr_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q    <= '0;
      state_q   <= SEARCH;
      run_q     <= '0;
      erun_q    <= '0;
      err_det_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hist_q    <= hist_d;
      state_q   <= state_d;
      run_q     <= run_d;
      erun_q    <= erun_d;
      err_det_q <= err_det_d;
      cnt_q     <= cnt_d;
    end
  end

  assign locked_o     = (state_q == LOCKED);
  assign err_detect_o = err_det_q;
  assign err_cnt_o    = cnt_q;

endmodule

// File: rtl/prbs_par_gen_chk.sv
// Parallel multi-polynomial PRBS generator with error injection, plus the matching checker.
module prbs_par_gen_chk
  import prbs_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned LOCK_CNT   = 16,
  parameter int unsigned UNLOCK_ERR = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [2:0]        mode_i,
  input  logic              en_i,
  input  logic              inj_err_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  input  logic              cnt_clr_i,
  output logic              locked_o,
  output logic              err_detect_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  logic [2:0]           mode_q;
  logic                 mode_chg;
  prbs_mode_t           mode;
  logic [MAX_ORDER-1:0] lfsr_q, lfsr_d;
  logic [DATA_W-1:0]    tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  prbs_step_t           step;
  logic                 unused_step;

  assign mode_chg    = (mode_i != mode_q);
  assign mode        = prbs_decode(mode_q);
  assign unused_step = ^step.bits;

  // A mode change takes priority over EN: that cycle only reseeds.
  always_comb begin
    step       = prbs_next(lfsr_q, mode, DATA_W);
    lfsr_d     = lfsr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    if (mode_chg) begin
      lfsr_d = '1;
    end else if (en_i) begin
      lfsr_d       = step.state;
      tx_data_d    = step.bits[DATA_W-1:0];
      tx_data_d[0] = step.bits[0] ^ inj_err_i;
      tx_valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q     <= 3'd0;
      lfsr_q     <= '1;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      mode_q     <= mode_i;
      lfsr_q     <= lfsr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;

  prbs_par_chk #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .LOCK_CNT  (LOCK_CNT),
    .UNLOCK_ERR(UNLOCK_ERR)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mode_i      (mode),
    .clear_i     (mode_chg),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .cnt_clr_i   (cnt_clr_i),
    .locked_o    (locked_o),
    .err_detect_o(err_detect_o),
    .err_cnt_o   (err_cnt_o)
  );

endmodule

// File: tb/tb_prbs_par_gen_chk.sv
// Bench for prbs_par_gen_chk: an 8-bit instance (CNT_W=4) and a 32-bit PRBS31 loopback instance.
module tb_prbs_par_gen_chk;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Instance A: DATA_W=8, CNT_W=4, optional loopback.
  logic [2:0] a_mode = 3'd0;
  logic       a_en = 0, a_inj = 0, a_rxv = 0, a_clr = 0, loop_a = 0;
  logic [7:0] a_rxd = 8'h00;
  logic [7:0] a_tx, a_rx;
  logic       a_txv, a_lock, a_det, a_rxv_w;
  logic [3:0] a_cnt;
  assign a_rx    = loop_a ? a_tx : a_rxd;
  assign a_rxv_w = loop_a ? a_txv : a_rxv;

  prbs_par_gen_chk #(.DATA_W(8), .CNT_W(4), .LOCK_CNT(16), .UNLOCK_ERR(4)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(a_mode), .en_i(a_en), .inj_err_i(a_inj),
    .tx_data_o(a_tx), .tx_valid_o(a_txv), .rx_data_i(a_rx), .rx_valid_i(a_rxv_w),
    .cnt_clr_i(a_clr), .locked_o(a_lock), .err_detect_o(a_det), .err_cnt_o(a_cnt)
  );

  // Instance B: DATA_W=32 in PRBS31, permanently looped back.
  logic [2:0]  b_mode = 3'd4;
  logic        b_en = 0;
  logic [31:0] b_tx;
  logic        b_txv, b_lock, b_det;
  logic [15:0] b_cnt;

  prbs_par_gen_chk #(.DATA_W(32), .CNT_W(16), .LOCK_CNT(16), .UNLOCK_ERR(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(b_mode), .en_i(b_en), .inj_err_i(1'b0),
    .tx_data_o(b_tx), .tx_valid_o(b_txv), .rx_data_i(b_tx), .rx_valid_i(b_txv),
    .cnt_clr_i(1'b0), .locked_o(b_lock), .err_detect_o(b_det), .err_cnt_o(b_cnt)
  );

  // Reference model: bit sequences obey b[t] = b[t-order] ^ b[t-tap].
  bit         ga[$], ra[$], gb[$];
  logic [2:0] ma_mode;
  logic [7:0] ea_tx;
  logic       ea_txv, ea_lock, ea_det;
  int         ea_cnt, ea_run, ea_erun;
  logic [31:0] eb_tx;
  logic        eb_txv;

  function automatic int ord_of(input logic [2:0] m);
    case (m)
      3'd1: return 9;
      3'd2: return 15;
      3'd3: return 23;
      3'd4: return 31;
      default: return 7;
    endcase
  endfunction

  function automatic int tap_of(input logic [2:0] m);
    case (m)
      3'd1: return 5;
      3'd2: return 14;
      3'd3: return 18;
      3'd4: return 28;
      default: return 6;
    endcase
  endfunction

  // Generator "prehistory" is all ones (the seed); checker prehistory is all zeros.
  task automatic seed_a();
    ga.delete();
    ra.delete();
    for (int i = 0; i < 31; i++) begin
      ga.push_back(1'b1);
      ra.push_back(1'b0);
    end
  endtask

  task automatic model_reset();
    seed_a();
    gb.delete();
    for (int i = 0; i < 31; i++) gb.push_back(1'b1);
    ma_mode = 3'd0;
    ea_tx = 8'h00; ea_txv = 0; ea_lock = 0; ea_det = 0;
    ea_cnt = 0; ea_run = 0; ea_erun = 0;
    eb_tx = '0; eb_txv = 0;
  endtask

  // Predicts what the next clock edge does with the inputs currently driven.
  task automatic model_step();
    logic [7:0]  rxw, w;
    logic [31:0] wb;
    logic        rxv, nb, e;
    int          mm, o, t;
    rxw = loop_a ? ea_tx : a_rxd;
    rxv = loop_a ? ea_txv : a_rxv;
    ea_det = 0;
    if (a_mode !== ma_mode) begin
      ma_mode = a_mode;
      seed_a();
      ea_lock = 0; ea_run = 0; ea_erun = 0; ea_txv = 0;
    end else begin
      o = ord_of(ma_mode);
      t = tap_of(ma_mode);
      if (rxv) begin
        mm = 0;
        for (int i = 7; i >= 0; i--) begin
          e = ra[ra.size() - o] ^ ra[ra.size() - t];
          if (rxw[i] != e) mm++;
          ra.push_back(rxw[i]);
          if (ra.size() > 64) void'(ra.pop_front());
        end
        if (!ea_lock) begin
          if (mm == 0 && rxw != 8'h00) begin
            ea_run++;
            if (ea_run == 16) begin ea_lock = 1; ea_run = 0; end
          end else ea_run = 0;
        end else begin
          ea_cnt = (ea_cnt + mm > 15) ? 15 : ea_cnt + mm;
          if (mm != 0) begin
            ea_det = 1;
            ea_erun++;
            if (ea_erun == 4) begin ea_lock = 0; ea_erun = 0; end
          end else ea_erun = 0;
        end
      end
      if (a_en) begin
        w = 8'h00;
        for (int i = 0; i < 8; i++) begin
          nb = ga[ga.size() - o] ^ ga[ga.size() - t];
          ga.push_back(nb);
          if (ga.size() > 64) void'(ga.pop_front());
          w = {w[6:0], nb};
        end
        w[0] = w[0] ^ a_inj;
        ea_tx  = w;
        ea_txv = 1;
      end else ea_txv = 0;
    end
    if (a_clr) ea_cnt = 0;
    if (b_en) begin
      wb = '0;
      for (int i = 0; i < 32; i++) begin
        nb = gb[gb.size() - 31] ^ gb[gb.size() - 28];
        gb.push_back(nb);
        if (gb.size() > 64) void'(gb.pop_front());
        wb = {wb[30:0], nb};
      end
      eb_tx = wb;
    end
    eb_txv = b_en;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a_tx !== 8'h00) begin failures++; $display("FAIL reset_tx got=%h exp=00", a_tx); end
    checks++; if (a_txv !== 1'b0) begin failures++; $display("FAIL reset_txv got=%b exp=0", a_txv); end
    checks++; if (a_lock !== 1'b0) begin failures++; $display("FAIL reset_lock got=%b exp=0", a_lock); end
    checks++; if (a_det !== 1'b0) begin failures++; $display("FAIL reset_det got=%b exp=0", a_det); end
    checks++; if (a_cnt !== 4'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
    checks++; if (b_lock !== 1'b0) begin failures++; $display("FAIL reset_b_lock got=%b exp=0", b_lock); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loop_prbs7();
    int dut_lock_at = -1, mod_lock_at = -1;
    loop_a = 1; a_en = 1; a_mode = 3'd0;
    for (int c = 1; c <= 1000; c++) begin
      tick();
      checks++;
      if (a_tx !== ea_tx || a_txv !== ea_txv) begin
        failures++; $display("FAIL loop7_tx cyc=%0d got=%h/%b exp=%h/%b", c, a_tx, a_txv, ea_tx, ea_txv);
      end
      if (a_lock === 1'b1 && dut_lock_at < 0) dut_lock_at = c;
      if (ea_lock && mod_lock_at < 0) mod_lock_at = c;
    end
    checks++; if (dut_lock_at != mod_lock_at) begin failures++; $display("FAIL loop7_lock_cycle got=%0d exp=%0d", dut_lock_at, mod_lock_at); end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL loop7_locked got=%b exp=1", a_lock); end
    checks++; if (a_cnt !== 4'd0) begin failures++; $display("FAIL loop7_cnt got=%0d exp=0", a_cnt); end
  endtask

  task automatic test_inject();
    int  pulses = 0;
    bit  dropped = 0;
    for (int c = 1; c <= 80; c++) begin
      a_inj = (c == 50);
      tick();
      a_inj = 0;
      if (a_det === 1'b1) pulses++;
      if (a_lock !== 1'b1) dropped = 1;
      checks++;
      if (a_tx !== ea_tx) begin failures++; $display("FAIL inj_tx cyc=%0d got=%h exp=%h", c, a_tx, ea_tx); end
    end
    checks++; if (a_cnt !== 4'd3) begin failures++; $display("FAIL inj_cnt got=%0d exp=3", a_cnt); end
    checks++; if (pulses < 1 || pulses > 2) begin failures++; $display("FAIL inj_pulses got=%0d exp=1..2", pulses); end
    checks++; if (dropped) begin failures++; $display("FAIL inj_lock_dropped got=1 exp=0"); end
  endtask

  task automatic test_cnt_sat();
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 10; c++) begin
        a_inj = (c == 0);
        tick();
        a_inj = 0;
      end
    end
    checks++; if (a_cnt !== 4'd15) begin failures++; $display("FAIL sat_cnt got=%0d exp=15", a_cnt); end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL sat_lock got=%b exp=1", a_lock); end
    // Injected word arrives with one bad bit while the clear is asserted; two more follow next word.
    a_inj = 1; tick(); a_inj = 0;
    a_clr = 1; tick(); a_clr = 0;
    checks++; if (a_cnt !== 4'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", a_cnt); end
    checks++; if (a_det !== 1'b1) begin failures++; $display("FAIL clr_det got=%b exp=1", a_det); end
    tick();
    checks++; if (a_cnt !== 4'd2) begin failures++; $display("FAIL clr_after got=%0d exp=2", a_cnt); end
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_unlock();
    int dut_at = -1, mod_at = -1;
    loop_a = 0; a_rxv = 1;
    for (int c = 1; c <= 12; c++) begin
      a_rxd = 8'($urandom);
      tick();
      if (a_lock === 1'b0 && dut_at < 0) dut_at = c;
      if (!ea_lock && mod_at < 0) mod_at = c;
      checks++;
      if (a_det !== ea_det) begin failures++; $display("FAIL unlock_det cyc=%0d got=%b exp=%b", c, a_det, ea_det); end
    end
    checks++; if (dut_at != mod_at) begin failures++; $display("FAIL unlock_cycle got=%0d exp=%0d", dut_at, mod_at); end
    checks++; if (a_cnt !== 4'(ea_cnt)) begin failures++; $display("FAIL unlock_cnt got=%0d exp=%0d", a_cnt, ea_cnt); end
    a_rxd = 8'h00;
    for (int c = 1; c <= 200; c++) begin
      tick();
      checks++;
      if (a_lock !== 1'b0) begin failures++; $display("FAIL dead_line_lock cyc=%0d got=%b exp=0", c, a_lock); end
    end
    a_rxv = 0;
  endtask

  task automatic test_reset_mid();
    loop_a = 1; a_en = 1;
    for (int c = 0; c < 40; c++) tick();
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL relock_before_rst got=%b exp=1", a_lock); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (a_tx !== 8'h00 || a_txv !== 1'b0) begin failures++; $display("FAIL rst_mid_tx got=%h/%b exp=00/0", a_tx, a_txv); end
    checks++; if (a_lock !== 1'b0 || a_det !== 1'b0) begin failures++; $display("FAIL rst_mid_lock got=%b/%b exp=0/0", a_lock, a_det); end
    checks++; if (a_cnt !== 4'd0) begin failures++; $display("FAIL rst_mid_cnt got=%0d exp=0", a_cnt); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      checks++;
      if (a_tx !== ea_tx || a_lock !== ea_lock) begin
        failures++; $display("FAIL post_rst cyc=%0d got=%h/%b exp=%h/%b", c, a_tx, a_lock, ea_tx, ea_lock);
      end
    end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL post_rst_lock got=%b exp=1", a_lock); end
  endtask

  task automatic test_mode_change();
    logic [3:0] cnt_before;
    a_inj = 1; tick(); a_inj = 0;
    for (int c = 0; c < 4; c++) tick();
    cnt_before = a_cnt;
    checks++; if (cnt_before !== 4'd3) begin failures++; $display("FAIL mode_pre_cnt got=%0d exp=3", cnt_before); end
    a_mode = 3'd4;
    tick();
    checks++; if (a_lock !== 1'b0 || a_txv !== 1'b0 || a_det !== 1'b0) begin
      failures++; $display("FAIL mode_chg_state got=%b/%b/%b exp=0/0/0", a_lock, a_txv, a_det);
    end
    checks++; if (a_cnt !== cnt_before) begin failures++; $display("FAIL mode_chg_cnt got=%0d exp=%0d", a_cnt, cnt_before); end
    for (int c = 1; c <= 300; c++) begin
      tick();
      checks++;
      if (a_tx !== ea_tx || a_lock !== ea_lock) begin
        failures++; $display("FAIL prbs31_w8 cyc=%0d got=%h/%b exp=%h/%b", c, a_tx, a_lock, ea_tx, ea_lock);
      end
    end
    checks++; if (a_lock !== 1'b1) begin failures++; $display("FAIL mode_relock got=%b exp=1", a_lock); end
    checks++; if (a_cnt !== cnt_before) begin failures++; $display("FAIL mode_relock_cnt got=%0d exp=%0d", a_cnt, cnt_before); end
  endtask

  task automatic test_prbs31_w32();
    int words = 0, cycles = 0;
    bit det_seen = 0;
    a_en = 0;
    while (words < 10000 && cycles < 40000) begin
      b_en = 1'($urandom);
      tick();
      cycles++;
      if (b_det === 1'b1) det_seen = 1;
      checks++;
      if (b_txv !== eb_txv || (eb_txv && b_tx !== eb_tx)) begin
        failures++; $display("FAIL b_tx cyc=%0d got=%h/%b exp=%h/%b", cycles, b_tx, b_txv, eb_tx, eb_txv);
      end
      if (eb_txv) words++;
    end
    b_en = 0;
    tick(); tick();
    checks++; if (words < 10000) begin failures++; $display("FAIL b_timeout got=%0d exp=10000", words); end
    checks++; if (b_lock !== 1'b1) begin failures++; $display("FAIL b_lock got=%b exp=1", b_lock); end
    checks++; if (b_cnt !== 16'd0) begin failures++; $display("FAIL b_cnt got=%0d exp=0", b_cnt); end
    checks++; if (det_seen) begin failures++; $display("FAIL b_det got=1 exp=0"); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_loop_prbs7();
    test_inject();
    test_cnt_sat();
    test_unlock();
    test_reset_mid();
    test_mode_change();
    test_prbs31_w32();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
